brom_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one single-port 1024x16 block ROM (read latency LAT) between NREQ independent requesters. Each requester issues addresses over a valid/ready handshake. The block accepts at most one request per cycle, drives the ROM address port and returns the read word with a one-hot response strobe after a fixed latency. It sits between requester logic and the ROM primitive, and the ROM instance is unchanged.

---
 rtl/brom_rr_arbiter.sv | 74 +++++++
 tb/tb_brom_rr_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/brom_rr_arbiter.sv
// Round-robin arbiter sharing one block ROM between NREQ requesters.
// One accept per cycle; a one-hot tag pipeline marks the owner of each read word.
module brom_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 10,
    parameter int DW   = 16,
    parameter int LAT  = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_data,
    output logic [AW-1:0]      rom_addr,
    input  logic [DW-1:0]      rom_data
);

    localparam int IW = $clog2(NREQ);

    logic [IW-1:0]            last_grant;
    logic [IW-1:0]            grant_idx;
    logic [NREQ-1:0]          grant;
    logic                     accept;
    logic [LAT:0][NREQ-1:0]   tag_pipe;

    // Search starts one past the last winner and wraps, so the first hit
    // in this order is the round-robin winner.
    always_comb begin : grant_search
        logic found;
        int   idx;
        grant     = '0;
        grant_idx = last_grant;
        found     = 1'b0;
        idx       = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_grant) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
                found      = 1'b1;
            end
        end
    end

    // Requests are ignored while reset is high so nothing is accepted then.
    assign req_ready = reset ? '0 : grant;
    assign accept    = |req_ready;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would let tag_pipe stages collapse.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= IW'(NREQ - 1);
            rom_addr   <= '0;
            tag_pipe   <= '0;
        end else begin
            if (accept) begin
                last_grant <= grant_idx;
                rom_addr   <= req_addr[int'(grant_idx)*AW +: AW];
            end
            // req_ready is zero on idle cycles, so bubbles shift in naturally.
            tag_pipe[0] <= req_ready;
            for (int i = 1; i <= LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign rsp_valid = tag_pipe[LAT];
    assign rsp_data  = rom_data;

endmodule

// File: tb/tb_brom_rr_arbiter.sv
// Directed bench for brom_rr_arbiter with a one-cycle ROM model and a
// scoreboard queue of expected responses keyed by due cycle.
module tb_brom_rr_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 10;
    localparam int DW   = 16;
    localparam int LAT  = 1;

    logic               clock;
    logic               reset;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_data;
    logic [AW-1:0]      rom_addr;
    logic [DW-1:0]      rom_data;
    logic [DW-1:0]      rom_q;

    brom_rr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .LAT(LAT)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ROM model: word[a] = a ^ 16'hA5A5, one cycle of read latency.
    always_ff @(posedge clock) rom_q <= {6'b0, rom_addr} ^ 16'hA5A5;
    assign rom_data = rom_q;

    typedef struct {
        logic [NREQ-1:0] onehot;
        logic [DW-1:0]   data;
        int              due;
    } exp_t;

    exp_t            sb[$];
    int              checks = 0;
    int              errors = 0;
    int              cyc    = 0;
    logic [NREQ-1:0] pend   = '0;
    logic [AW-1:0]   pend_addr [NREQ];
    logic [NREQ-1:0] seen_ready;
    int              wait2;
    int              max_wait2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        req_addr[i*AW +: AW] = a;
    endtask

    // One clock cycle: sample at the falling edge, then advance past the rising edge.
    task automatic step(input logic [NREQ-1:0] exp_ready);
        exp_t e;
        bit   ok;
        @(negedge clock);
        seen_ready = req_ready;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        while (sb.size() > 0 && sb[0].due < cyc) begin
            e = sb.pop_front();
            check("rsp_missing", 32'(e.due), 32'(cyc));
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check("rsp_valid", 32'(rsp_valid), 32'(e.onehot));
            check("rsp_data", 32'(rsp_data), 32'(e.data));
        end else begin
            check("rsp_idle", 32'(rsp_valid), 32'(0));
        end
        if (reset) begin
            sb.delete();
            pend = '0;
        end else begin
            if (pend != '0) begin
                ok = 1'b1;
                for (int i = 0; i < NREQ; i++)
                    if (pend[i] && (!req_valid[i] || req_addr[i*AW +: AW] != pend_addr[i]))
                        ok = 1'b0;
                check("hold_rule", 32'(ok), 32'(1));
            end
            pend = req_valid & ~exp_ready;
            for (int i = 0; i < NREQ; i++) pend_addr[i] = req_addr[i*AW +: AW];
            for (int i = 0; i < NREQ; i++) begin
                if (exp_ready[i]) begin
                    e.onehot = exp_ready;
                    e.data   = {6'b0, req_addr[i*AW +: AW]} ^ 16'hA5A5;
                    e.due    = cyc + 1 + LAT;
                    sb.push_back(e);
                end
            end
        end
        @(posedge clock);
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        step(4'b0000);
        reset     = 1'b0;
    endtask

    task automatic drain(input int n);
        req_valid = '0;
        for (int i = 0; i < n; i++) step(4'b0000);
    endtask

    // With the pointer at 3 and requesters 0..2 still pending, let them finish in order.
    task automatic tail3();
        req_valid = 4'b0111; step(4'b0001);
        req_valid = 4'b0110; step(4'b0010);
        req_valid = 4'b0100; step(4'b0100);
        req_valid = 4'b0000;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        step(4'b0000);
        step(4'b0000);
        check("reset_rom_addr", 32'(rom_addr), 32'(0));
        reset = 1'b0;

        // Single request.
        req_valid = 4'b0001;
        set_addr(0, 10'h005);
        step(4'b0001);
        check("single_rom_addr", 32'(rom_addr), 32'h005);
        drain(2);

        // All four continuously valid: strict rotation, no bubbles.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_addr(i, AW'(i));
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) step(4'(1 << (k % NREQ)));
        tail3();
        drain(2);

        // Fairness over 100 cycles with requester 2 watched.
        do_reset();
        set_addr(0, 10'h100); set_addr(1, 10'h155);
        set_addr(2, 10'h2AA); set_addr(3, 10'h3C3);
        req_valid = 4'b1111;
        wait2 = 0;
        max_wait2 = 0;
        for (int k = 0; k < 100; k++) begin
            step(4'(1 << (k % NREQ)));
            wait2 = seen_ready[2] ? 0 : wait2 + 1;
            if (wait2 > max_wait2) max_wait2 = wait2;
        end
        check("req2_max_wait", 32'(max_wait2 <= NREQ - 1), 32'(1));
        tail3();
        drain(2);

        // Wrap-around: grant 3, then 0 alone, then 3 ahead of 0.
        set_addr(3, 10'h0AB); set_addr(0, 10'h054);
        req_valid = 4'b1000; step(4'b1000);
        req_valid = 4'b0001; step(4'b0001);
        set_addr(0, 10'h0F0);
        req_valid = 4'b1001; step(4'b1000);
        req_valid = 4'b0001; step(4'b0001);
        drain(2);

        // Reset while a response is in flight.
        set_addr(0, 10'h3FF);
        req_valid = 4'b0001; step(4'b0001);
        reset = 1'b1;
        req_valid = 4'b1111; step(4'b0000);
        reset = 1'b0;
        check("flush_rom_addr", 32'(rom_addr), 32'(0));
        for (int i = 0; i < NREQ; i++) set_addr(i, AW'(10'h040 + i));
        req_valid = 4'b1111; step(4'b0001);
        req_valid = 4'b1110; step(4'b0010);
        req_valid = 4'b1100; step(4'b0100);
        req_valid = 4'b1000; step(4'b1000);
        drain(2);

        // Back-to-back from a single requester.
        req_valid = 4'b0010;
        set_addr(1, 10'h010); step(4'b0010);
        set_addr(1, 10'h011); step(4'b0010);
        set_addr(1, 10'h012); step(4'b0010);
        drain(2);

        check("sb_empty", 32'(sb.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
